// File: rtl/pifo_dequeue_scheduler.sv
// PIFO dequeue scheduler: arbitrates between a bypass entry and the PIFO top.
// Optional per-source pop counters are built when PIFO_DEQ_STATS_EN is defined.
module pifo_dequeue_scheduler #(
  parameter int RANK_WIDTH       = 32,
  parameter int MAX_BYPASS_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_bypass_valid,
  input  logic                  s_bypass_en,
  input  logic [RANK_WIDTH-1:0] s_bypass_rank,
  input  logic                  s_pifo_valid,
  input  logic [RANK_WIDTH-1:0] s_pifo_rank,
  input  logic                  s_gpfc_valid,
  input  logic [RANK_WIDTH-1:0] s_gpfc_pause_rank,
  input  logic                  m_tx_ready,
  input  logic                  m_tx_done,
  output logic                  m_pop_bypass,
  output logic                  m_pop_pifo,
  output logic                  m_valid,
  output logic [RANK_WIDTH-1:0] m_rank,
`ifdef PIFO_DEQ_STATS_EN
  output logic [31:0]           m_stat_bypass_cnt,
  output logic [31:0]           m_stat_pifo_cnt,
`endif
  output logic                  m_src
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BYPASS_BURST);
  localparam logic [3:0] BURST_SAT = 4'hF;
  localparam logic [RANK_WIDTH-1:0] RANK_ONES = '1;

  logic [0:0]            state;
  logic [3:0]            burst_cnt;
  logic                  pause_active;
  logic [RANK_WIDTH-1:0] pause_rank;

  logic paused_b;
  logic paused_p;
  logic elig_b;
  logic elig_p;
  logic decide;
  logic pick_b;

  // Eligibility and the bypass-versus-PIFO choice for this cycle.
  always_comb begin
    paused_b = pause_active && (s_bypass_rank >= pause_rank);
    paused_p = pause_active && (s_pifo_rank >= pause_rank);
    elig_b   = s_bypass_valid && s_bypass_en && !paused_b;
    elig_p   = s_pifo_valid && !paused_p;
    decide   = (state == IDLE) && m_tx_ready && (elig_b || elig_p);
    pick_b   = elig_b && (!elig_p || (burst_cnt < BURST_MAX));
  end

  assign m_valid = (state == BUSY);

  // Grant FSM: a decision in IDLE registers the grant and moves to BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_pop_bypass <= 1'b0;
      m_pop_pifo   <= 1'b0;
      m_rank       <= '0;
      m_src        <= 1'b0;
    end else begin
      m_pop_bypass <= 1'b0;
      m_pop_pifo   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (decide) begin
            state        <= BUSY;
            m_pop_bypass <= pick_b;
            m_pop_pifo   <= !pick_b;
            m_rank       <= pick_b ? s_bypass_rank : s_pifo_rank;
            m_src        <= pick_b;
          end
        end
        BUSY: begin
          if (m_tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bypass burst limiter: counts bypass grants that starved an eligible PIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (decide) begin
      if (pick_b && elig_p) begin
        if (burst_cnt != BURST_SAT) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Pause threshold; an all-ones rank releases the pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_active <= 1'b0;
      pause_rank   <= RANK_ONES;
    end else if (s_gpfc_valid) begin
      pause_rank   <= s_gpfc_pause_rank;
      pause_active <= (s_gpfc_pause_rank != RANK_ONES);
    end
  end

`ifdef PIFO_DEQ_STATS_EN
  // Wrapping per-source pop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stat_bypass_cnt <= '0;
      m_stat_pifo_cnt   <= '0;
    end else begin
      if (m_pop_bypass) m_stat_bypass_cnt <= m_stat_bypass_cnt + 32'd1;
      if (m_pop_pifo)   m_stat_pifo_cnt   <= m_stat_pifo_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pifo_dequeue_scheduler.sv
// Directed bench for pifo_dequeue_scheduler.
// Vector table for single grants plus hand sequences for multi-cycle cases.
module tb_pifo_dequeue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_bypass_valid, s_bypass_en;
  logic [31:0] s_bypass_rank;
  logic        s_pifo_valid;
  logic [31:0] s_pifo_rank;
  logic        s_gpfc_valid;
  logic [31:0] s_gpfc_pause_rank;
  logic        m_tx_ready, m_tx_done;
  logic        m_pop_bypass, m_pop_pifo, m_valid, m_src;
  logic [31:0] m_rank;
`ifdef PIFO_DEQ_STATS_EN
  logic [31:0] m_stat_bypass_cnt, m_stat_pifo_cnt;
`endif

  int total = 0;
  int passed = 0;

  pifo_dequeue_scheduler #(.RANK_WIDTH(32), .MAX_BYPASS_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .s_bypass_valid(s_bypass_valid), .s_bypass_en(s_bypass_en),
    .s_bypass_rank(s_bypass_rank),
    .s_pifo_valid(s_pifo_valid), .s_pifo_rank(s_pifo_rank),
    .s_gpfc_valid(s_gpfc_valid), .s_gpfc_pause_rank(s_gpfc_pause_rank),
    .m_tx_ready(m_tx_ready), .m_tx_done(m_tx_done),
    .m_pop_bypass(m_pop_bypass), .m_pop_pifo(m_pop_pifo),
    .m_valid(m_valid), .m_rank(m_rank),
`ifdef PIFO_DEQ_STATS_EN
    .m_stat_bypass_cnt(m_stat_bypass_cnt),
    .m_stat_pifo_cnt(m_stat_pifo_cnt),
`endif
    .m_src(m_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        bv, ben;
    logic [31:0] br;
    logic        pv;
    logic [31:0] pr;
    logic        rdy;
    logic        e_grant, e_src;
    logic [31:0] e_rank;
  } vec_t;

  vec_t vecs[10];

  // {pop_b, pop_p, valid, src, rank}
  function automatic logic [35:0] outs();
    return {m_pop_bypass, m_pop_pifo, m_valid, m_src, m_rank};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_in();
    s_bypass_valid = 0; s_bypass_en = 0; s_bypass_rank = 0;
    s_pifo_valid = 0; s_pifo_rank = 0;
    s_gpfc_valid = 0; s_gpfc_pause_rank = 0;
    m_tx_ready = 1; m_tx_done = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic finish_tx();
    @(negedge clk);
    clear_in();
    m_tx_done = 1;
    tick();
    m_tx_done = 0;
  endtask

  task automatic gpfc(input logic [31:0] r);
    @(negedge clk);
    s_gpfc_valid = 1; s_gpfc_pause_rank = r;
    @(negedge clk);
    s_gpfc_valid = 0;
  endtask

  logic [9:0] order;
  bit         timed_out;
  int         cyc;

  initial begin
    vecs[0] = '{"pifo_only", 0, 0, 0, 1, 32'h10, 1, 1, 0, 32'h10};
    vecs[1] = '{"byp_only", 1, 1, 32'h5, 0, 0, 1, 1, 1, 32'h5};
    vecs[2] = '{"byp_dis", 1, 0, 32'h7, 0, 0, 1, 0, 0, 0};
    vecs[3] = '{"both_b", 1, 1, 32'h7, 1, 32'h9, 1, 1, 1, 32'h7};
    vecs[4] = '{"not_rdy", 1, 1, 32'h7, 1, 32'h9, 0, 0, 0, 0};
    vecs[5] = '{"none", 0, 1, 32'h1, 0, 32'h2, 1, 0, 0, 0};
    vecs[6] = '{"dis_pifo", 1, 0, 32'h3, 1, 32'h22, 1, 1, 0, 32'h22};
    vecs[7] = '{"byp_max", 1, 1, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 32'hFFFF_FFFF};
    vecs[8] = '{"pifo_zero", 0, 0, 0, 1, 32'h0, 1, 1, 0, 32'h0};
    vecs[9] = '{"both_b2", 1, 1, 32'h0, 1, 32'h1, 1, 1, 1, 32'h0};

    clear_in();
    rst = 1;
    #1;
    check("rst_outs", 64'(outs()), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    tick();
    check("post_rst", 64'(outs()), 64'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_bypass_valid = vecs[i].bv; s_bypass_en = vecs[i].ben;
      s_bypass_rank = vecs[i].br;
      s_pifo_valid = vecs[i].pv; s_pifo_rank = vecs[i].pr;
      m_tx_ready = vecs[i].rdy;
      tick();
      check({vecs[i].name, "_pop"},
            64'({m_pop_bypass, m_pop_pifo, m_valid}),
            64'({vecs[i].e_grant & vecs[i].e_src,
                 vecs[i].e_grant & ~vecs[i].e_src, vecs[i].e_grant}));
      if (vecs[i].e_grant)
        check({vecs[i].name, "_data"}, 64'({m_src, m_rank}),
              64'({vecs[i].e_src, vecs[i].e_rank}));
      finish_tx();
      check({vecs[i].name, "_end"},
            64'({m_pop_bypass, m_pop_pifo, m_valid}), 64'h0);
    end

    // grant holds while busy, no new decision
    @(negedge clk);
    s_pifo_valid = 1; s_pifo_rank = 32'h10;
    tick();
    check("hold_grant", 64'(outs()), 64'({3'b011, 1'b0, 32'h10}));
    @(negedge clk);
    s_bypass_valid = 1; s_bypass_en = 1; s_bypass_rank = 32'h3;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_busy", 64'(outs()), 64'({3'b001, 1'b0, 32'h10}));
    end
    finish_tx();
    check("hold_end", 64'({m_pop_bypass, m_pop_pifo, m_valid}), 64'h0);

    // pause: pifo paused, bypass below threshold granted
    gpfc(32'h20);
    @(negedge clk);
    s_bypass_valid = 1; s_bypass_en = 1; s_bypass_rank = 32'h5;
    s_pifo_valid = 1; s_pifo_rank = 32'h30;
    tick();
    check("pause_byp", 64'(outs()), 64'({3'b101, 1'b1, 32'h5}));
    finish_tx();
    @(negedge clk);
    s_pifo_valid = 1; s_pifo_rank = 32'h20;
    tick();
    tick();
    check("pause_eq", 64'({m_pop_bypass, m_pop_pifo, m_valid}), 64'h0);
    @(negedge clk);
    s_pifo_rank = 32'h1F;
    tick();
    check("pause_below", 64'(outs()), 64'({3'b011, 1'b0, 32'h1F}));
    finish_tx();
    @(negedge clk);
    s_pifo_valid = 1; s_pifo_rank = 32'h30;
    s_gpfc_valid = 1; s_gpfc_pause_rank = 32'hFFFF_FFFF;
    tick();
    check("rel_same_cyc", 64'({m_pop_bypass, m_pop_pifo, m_valid}), 64'h0);
    @(negedge clk);
    s_gpfc_valid = 0;
    tick();
    check("rel_grant", 64'(outs()), 64'({3'b011, 1'b0, 32'h30}));
    @(negedge clk);
    s_pifo_valid = 0;
    s_gpfc_valid = 1; s_gpfc_pause_rank = 32'h10;
    tick();
    tick();
    check("pause_no_revoke", 64'(outs()), 64'({3'b001, 1'b0, 32'h30}));
    finish_tx();
    gpfc(32'hFFFF_FFFF);

    // reset while busy
    @(negedge clk);
    s_pifo_valid = 1; s_pifo_rank = 32'h44;
    tick();
    check("rb_grant", 64'(outs()), 64'({3'b011, 1'b0, 32'h44}));
    #1;
    rst = 1;
    #1;
    check("rb_immediate", 64'(outs()), 64'h0);
    tick();
    check("rb_no_pop", 64'(outs()), 64'h0);
    @(negedge clk);
    clear_in();
    rst = 0;

    // burst limiter, starting from a fresh burst count
    @(negedge clk);
    s_bypass_valid = 1; s_bypass_en = 1; s_bypass_rank = 32'hA;
    s_pifo_valid = 1; s_pifo_rank = 32'hB;
    order = '0;
    timed_out = 0;
    for (int g = 0; g < 10 && !timed_out; g++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!(m_pop_bypass || m_pop_pifo) && cyc < 8);
      if (!(m_pop_bypass || m_pop_pifo)) begin
        timed_out = 1;
        check("burst_timeout", 64'(g), 64'd10);
      end else begin
        order[9-g] = m_pop_bypass;
        @(negedge clk);
        m_tx_done = 1;
        @(negedge clk);
        m_tx_done = 0;
        if (g == 9) clear_in();
      end
    end
    check("burst_order", 64'(order), 64'(10'b1111011110));
`ifdef PIFO_DEQ_STATS_EN
    tick();
    check("stat_bypass", 64'(m_stat_bypass_cnt), 64'd8);
    check("stat_pifo", 64'(m_stat_pifo_cnt), 64'd2);
`endif
    finish_tx();
    check("final_idle", 64'({m_pop_bypass, m_pop_pifo, m_valid}), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
